// File: rtl/vector_cache_pkg.sv
// Shared vector-cache constants and the evict-data-buffer group state type.
package vector_cache_pkg;

    localparam int EVDB_ENTRY_NUM = 32;
    localparam int EVDB_GRP_NUM_DFLT = EVDB_ENTRY_NUM / 4;
    localparam int GRP_IDX_W = $clog2(EVDB_GRP_NUM_DFLT);

    typedef enum logic [1:0] {
        GRP_IDLE   = 2'd0,
        GRP_ALLOC  = 2'd1,
        GRP_FILLED = 2'd2,
        GRP_DRAIN  = 2'd3
    } grp_state_e;

endpackage

// File: rtl/vec_cache_idx_fifo.sv
// In-order index FIFO; head read straight from flops so a push into an empty
// FIFO only shows up on the following cycle.
module vec_cache_idx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]                  wr_q, rd_q;
    logic [DEPTH-1:0][WIDTH-1:0]  mem_q;
    logic                         full, push_ok, pop_ok;

    // Address wraps at DEPTH (not necessarily a power of two); MSB toggles per lap.
    function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
        if (p[AW-1:0] == AW'(DEPTH - 1))
            return {~p[AW], {AW{1'b0}}};
        return p + (AW + 1)'(1);
    endfunction

    assign empty_o = (wr_q == rd_q);
    assign full    = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    assign push_ok = push_i && !full;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            mem_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q[AW-1:0]] <= push_data_i;
                wr_q                <= ptr_inc(wr_q);
            end
            if (pop_ok)
                rd_q <= ptr_inc(rd_q);
        end
    end

endmodule

// File: rtl/vec_cache_evdb_alloc_ctrl.sv
// Evict data buffer group allocator: IDLE->ALLOC->FILLED->DRAIN->IDLE per group,
// with filled groups drained downstream in fill order.
module vec_cache_evdb_alloc_ctrl
    import vector_cache_pkg::*;
#(
    parameter int EVDB_GRP_NUM  = EVDB_ENTRY_NUM / 4,
    parameter int GRP_IDX_WIDTH = $clog2(EVDB_GRP_NUM)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 alloc_req_vld,
    output logic                                 alloc_req_rdy,
    output logic [GRP_IDX_WIDTH-1:0]             alloc_grp_idx,
    input  logic                                 fill_done_vld,
    input  logic [GRP_IDX_WIDTH-1:0]             fill_done_grp_idx,
    output logic                                 drain_vld,
    output logic [GRP_IDX_WIDTH-1:0]             drain_grp_idx,
    input  logic                                 drain_rdy,
    input  logic                                 release_vld,
    input  logic [GRP_IDX_WIDTH-1:0]             release_grp_idx,
    output logic [$clog2(EVDB_GRP_NUM+1)-1:0]    free_cnt,
    output logic                                 err_sticky
);

    localparam int CNT_W = $clog2(EVDB_GRP_NUM + 1);

    grp_state_e                state_q [EVDB_GRP_NUM];
    grp_state_e                state_d [EVDB_GRP_NUM];
    logic [CNT_W-1:0]          free_cnt_q, free_cnt_d;
    logic                      err_q;
    logic                      alloc_fire, fill_ok, rel_ok, drain_fire, fifo_empty;
    logic [GRP_IDX_WIDTH-1:0]  head_idx;

    // Ready/grant come only from registered state, so a release frees its group next cycle.
    always_comb begin
        alloc_req_rdy = 1'b0;
        alloc_grp_idx = '0;
        for (int g = EVDB_GRP_NUM - 1; g >= 0; g--) begin
            if (state_q[g] == GRP_IDLE) begin
                alloc_req_rdy = 1'b1;
                alloc_grp_idx = GRP_IDX_WIDTH'(g);
            end
        end
    end

    assign alloc_fire    = alloc_req_vld && alloc_req_rdy;
    assign drain_vld     = !fifo_empty;
    assign drain_grp_idx = head_idx;
    assign drain_fire    = drain_vld && drain_rdy;

    // Each event is gated by the state it expects, so the four events can never collide on one group.
    always_comb begin
        state_d = state_q;
        fill_ok = 1'b0;
        rel_ok  = 1'b0;
        for (int g = 0; g < EVDB_GRP_NUM; g++) begin
            if (state_q[g] == GRP_IDLE && alloc_fire && alloc_grp_idx == GRP_IDX_WIDTH'(g))
                state_d[g] = GRP_ALLOC;
            if (state_q[g] == GRP_ALLOC && fill_done_vld && fill_done_grp_idx == GRP_IDX_WIDTH'(g)) begin
                state_d[g] = GRP_FILLED;
                fill_ok    = 1'b1;
            end
            if (state_q[g] == GRP_FILLED && drain_fire && head_idx == GRP_IDX_WIDTH'(g))
                state_d[g] = GRP_DRAIN;
            if (state_q[g] == GRP_DRAIN && release_vld && release_grp_idx == GRP_IDX_WIDTH'(g)) begin
                state_d[g] = GRP_IDLE;
                rel_ok     = 1'b1;
            end
        end
    end

    always_comb begin
        free_cnt_d = free_cnt_q;
        if (alloc_fire && !rel_ok)
            free_cnt_d = free_cnt_q - CNT_W'(1);
        else if (rel_ok && !alloc_fire)
            free_cnt_d = free_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < EVDB_GRP_NUM; g++)
                state_q[g] <= GRP_IDLE;
            free_cnt_q <= CNT_W'(EVDB_GRP_NUM);
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            free_cnt_q <= free_cnt_d;
            err_q      <= err_q | (fill_done_vld & ~fill_ok) | (release_vld & ~rel_ok);
        end
    end

    assign free_cnt   = free_cnt_q;
    assign err_sticky = err_q;

    vec_cache_idx_fifo #(
        .DEPTH (EVDB_GRP_NUM),
        .WIDTH (GRP_IDX_WIDTH)
    ) u_drain_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fill_ok),
        .push_data_i (fill_done_grp_idx),
        .pop_i       (drain_fire),
        .empty_o     (fifo_empty),
        .head_o      (head_idx)
    );

endmodule

// File: tb/tb_vec_cache_evdb_alloc_ctrl.sv
// Directed bench for the evict data buffer group allocator.
module tb_vec_cache_evdb_alloc_ctrl;
    import vector_cache_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alloc_req_vld, alloc_req_rdy;
    logic [2:0] alloc_grp_idx;
    logic       fill_done_vld;
    logic [2:0] fill_done_grp_idx;
    logic       drain_vld, drain_rdy;
    logic [2:0] drain_grp_idx;
    logic       release_vld;
    logic [2:0] release_grp_idx;
    logic [3:0] free_cnt;
    logic       err_sticky;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vec_cache_evdb_alloc_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .alloc_req_vld     (alloc_req_vld),
        .alloc_req_rdy     (alloc_req_rdy),
        .alloc_grp_idx     (alloc_grp_idx),
        .fill_done_vld     (fill_done_vld),
        .fill_done_grp_idx (fill_done_grp_idx),
        .drain_vld         (drain_vld),
        .drain_grp_idx     (drain_grp_idx),
        .drain_rdy         (drain_rdy),
        .release_vld       (release_vld),
        .release_grp_idx   (release_grp_idx),
        .free_cnt          (free_cnt),
        .err_sticky        (err_sticky)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        alloc_req_vld = 1'b0;
        fill_done_vld = 1'b0;
        drain_rdy     = 1'b0;
        release_vld   = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_rdy"},   32'(alloc_req_rdy), 32'd1);
        chk({tag, "_aidx"},  32'(alloc_grp_idx), 32'd0);
        chk({tag, "_dvld"},  32'(drain_vld),     32'd0);
        chk({tag, "_didx"},  32'(drain_grp_idx), 32'd0);
        chk({tag, "_free"},  32'(free_cnt),      32'd8);
        chk({tag, "_err"},   32'(err_sticky),    32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        quiet();
        fill_done_grp_idx = '0;
        release_grp_idx   = '0;
        #12;
        chk_reset_outs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // 8 back-to-back allocations
        alloc_req_vld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("alloc%0d_idx", i),  32'(alloc_grp_idx), 32'(i));
            chk($sformatf("alloc%0d_free", i), 32'(free_cnt),      32'(8 - i));
            chk($sformatf("alloc%0d_rdy", i),  32'(alloc_req_rdy), 32'd1);
            tick();
        end
        alloc_req_vld = 1'b0;
        chk("full_free", 32'(free_cnt),      32'd0);
        chk("full_rdy",  32'(alloc_req_rdy), 32'd0);

        // fill 5,2,7 then drain in order
        fill_done_vld = 1'b1;
        fill_done_grp_idx = 3'd5;
        chk("push_not_visible", 32'(drain_vld), 32'd0);
        tick();
        fill_done_grp_idx = 3'd2; tick();
        fill_done_grp_idx = 3'd7; tick();
        fill_done_vld = 1'b0;
        chk("st5_filled", 32'(dut.state_q[5]), 32'(GRP_FILLED));
        drain_rdy = 1'b1;
        chk("drain0_vld", 32'(drain_vld),     32'd1);
        chk("drain0_idx", 32'(drain_grp_idx), 32'd5);
        tick();
        chk("drain1_idx", 32'(drain_grp_idx), 32'd2);
        tick();
        chk("drain2_idx", 32'(drain_grp_idx), 32'd7);
        tick();
        drain_rdy = 1'b0;
        chk("drained_vld", 32'(drain_vld),       32'd0);
        chk("st5_drain",   32'(dut.state_q[5]),  32'(GRP_DRAIN));
        chk("st7_drain",   32'(dut.state_q[7]),  32'(GRP_DRAIN));

        // bring group 3 to DRAIN, then release it under a pending alloc
        fill_done_vld = 1'b1; fill_done_grp_idx = 3'd3; tick();
        fill_done_vld = 1'b0; drain_rdy = 1'b1; tick();
        drain_rdy = 1'b0;
        chk("st3_drain", 32'(dut.state_q[3]), 32'(GRP_DRAIN));
        alloc_req_vld = 1'b1;
        release_vld = 1'b1; release_grp_idx = 3'd3;
        chk("rel3_rdy_same", 32'(alloc_req_rdy), 32'd0);
        chk("rel3_free0",    32'(free_cnt),      32'd0);
        tick();
        release_vld = 1'b0;
        chk("rel3_st_idle", 32'(dut.state_q[3]), 32'(GRP_IDLE));
        chk("rel3_rdy",     32'(alloc_req_rdy),  32'd1);
        chk("rel3_idx",     32'(alloc_grp_idx),  32'd3);
        chk("rel3_free1",   32'(free_cnt),       32'd1);
        tick();
        alloc_req_vld = 1'b0;
        chk("realloc3_free", 32'(free_cnt),       32'd0);
        chk("realloc3_st",   32'(dut.state_q[3]), 32'(GRP_ALLOC));

        // make group 4 IDLE, then release it again (illegal)
        fill_done_vld = 1'b1; fill_done_grp_idx = 3'd4; tick();
        fill_done_vld = 1'b0; drain_rdy = 1'b1; tick();
        drain_rdy = 1'b0; release_vld = 1'b1; release_grp_idx = 3'd4; tick();
        chk("rel4_free", 32'(free_cnt),   32'd1);
        chk("rel4_err0", 32'(err_sticky), 32'd0);
        tick();
        release_vld = 1'b0;
        chk("badrel_err",  32'(err_sticky),      32'd1);
        chk("badrel_free", 32'(free_cnt),        32'd1);
        chk("badrel_st4",  32'(dut.state_q[4]),  32'(GRP_IDLE));
        chk("badrel_dvld", 32'(drain_vld),       32'd0);

        // states: 0A 1A 2D 3A 4I 5D 6A 7D; put 6 in the FIFO
        fill_done_vld = 1'b1; fill_done_grp_idx = 3'd6; tick();
        // same cycle: alloc 4, fill 0, drain 6, release 2
        alloc_req_vld = 1'b1;
        fill_done_grp_idx = 3'd0;
        drain_rdy = 1'b1;
        release_vld = 1'b1; release_grp_idx = 3'd2;
        chk("quad_aidx", 32'(alloc_grp_idx), 32'd4);
        chk("quad_didx", 32'(drain_grp_idx), 32'd6);
        tick();
        quiet();
        chk("quad_free", 32'(free_cnt),       32'd1);
        chk("quad_st4",  32'(dut.state_q[4]), 32'(GRP_ALLOC));
        chk("quad_st0",  32'(dut.state_q[0]), 32'(GRP_FILLED));
        chk("quad_st6",  32'(dut.state_q[6]), 32'(GRP_DRAIN));
        chk("quad_st2",  32'(dut.state_q[2]), 32'(GRP_IDLE));
        chk("quad_dvld", 32'(drain_vld),      32'd1);
        chk("quad_head", 32'(drain_grp_idx),  32'd0);
        chk("quad_next", 32'(alloc_grp_idx),  32'd2);

        // DRAIN: 5,6,7; FIFO: 0, then push 1 -> two entries, then async reset mid-cycle
        fill_done_vld = 1'b1; fill_done_grp_idx = 3'd1; tick();
        fill_done_vld = 1'b0;
        chk("pre_rst_head", 32'(drain_grp_idx), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("midrst");
        chk("midrst_st5", 32'(dut.state_q[5]), 32'(GRP_IDLE));
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        alloc_req_vld = 1'b1;
        chk("post_rst_idx", 32'(alloc_grp_idx), 32'd0);
        tick();
        alloc_req_vld = 1'b0;
        chk("post_rst_idx1", 32'(alloc_grp_idx), 32'd1);
        chk("post_rst_free", 32'(free_cnt),      32'd7);

        // fill on an IDLE group is ignored and flagged
        fill_done_vld = 1'b1; fill_done_grp_idx = 3'd3; tick();
        fill_done_vld = 1'b0;
        chk("badfill_err",  32'(err_sticky),     32'd1);
        chk("badfill_st3",  32'(dut.state_q[3]), 32'(GRP_IDLE));
        tick();
        chk("badfill_dvld", 32'(drain_vld),      32'd0);
        chk("badfill_free", 32'(free_cnt),       32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_cache_evdb_alloc_ctrl.md
VEC_CACHE_EVDB_ALLOC_CTRL -- requirements
Module: vec_cache_evdb_alloc_ctrl

Interface
REQ-001 SHALL have parameter EVDB_GRP_NUM, default EVDB_ENTRY_NUM/4 (8), number of 4-beat evict data buffer groups managed.
REQ-002 SHALL have parameter GRP_IDX_WIDTH, default $clog2(EVDB_GRP_NUM) (3), group index width.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk  in  1  block clock; rst_n  in  1  async active-low reset.
REQ-004 alloc_req_vld  in  1  evict request needs a buffer group.
REQ-005 alloc_req_rdy  out  1  an idle group exists.
REQ-006 alloc_grp_idx  out  GRP_IDX_WIDTH  group granted on alloc handshake.
REQ-007 fill_done_vld  in  1  last beat written into a group (evict_clean).
REQ-008 fill_done_grp_idx  in  GRP_IDX_WIDTH  group just filled.
REQ-009 drain_vld  out  1  a filled group is waiting to be read out downstream.
REQ-010 drain_grp_idx  out  GRP_IDX_WIDTH  oldest filled group.
REQ-011 drain_rdy  in  1  read-out sequencer accepts drain_grp_idx.
REQ-012 release_vld  in  1  downstream last-beat handshake done for a group.
REQ-013 release_grp_idx  in  GRP_IDX_WIDTH  group to free.
REQ-014 free_cnt  out  $clog2(EVDB_GRP_NUM+1)  idle group count.
REQ-015 err_sticky  out  1  illegal fill/release event seen.

Function
REQ-016 Each group SHALL hold a 2-bit state: IDLE, ALLOC, FILLED, DRAIN.
REQ-017 alloc_req_rdy SHALL be 1 iff any group is IDLE, derived from registered state only (no path from alloc_req_vld).
REQ-018 alloc_grp_idx SHALL be the lowest-index IDLE group; on alloc_req_vld&&alloc_req_rdy that group SHALL go IDLE->ALLOC next cycle.
REQ-019 fill_done_vld on an ALLOC group SHALL move it to FILLED and push its index into an in-order drain FIFO of depth EVDB_GRP_NUM.
REQ-020 drain_vld SHALL equal FIFO non-empty; drain_grp_idx SHALL be FIFO head; on drain_vld&&drain_rdy SHALL pop and move that group FILLED->DRAIN.
REQ-021 release_vld on a DRAIN group SHALL move it to IDLE.
REQ-022 fill_done on a non-ALLOC group or release on a non-DRAIN group SHALL be ignored (no state, FIFO or count change) and SHALL set err_sticky.
REQ-023 free_cnt SHALL decrement on alloc handshake, increment on legal release, unchanged when both occur same cycle; never wraps.
REQ-024 A group released in cycle N SHALL not be allocatable before cycle N+1.
REQ-025 Fill push and drain pop in the same cycle SHALL both take effect; when the FIFO is empty, a push SHALL not be visible on drain_vld until the next cycle.
REQ-026 FIFO SHALL never overflow: at most EVDB_GRP_NUM entries by construction; read/write pointers wrap modulo EVDB_GRP_NUM with an extra wrap bit for full/empty.
REQ-027 Alloc, fill, drain and release on four different groups in one cycle SHALL all take effect.

Reset
REQ-028 On rst_n low, asynchronously: all groups IDLE, FIFO empty, free_cnt=EVDB_GRP_NUM, alloc_req_rdy=1, alloc_grp_idx=0, drain_vld=0, drain_grp_idx=0, err_sticky=0.
REQ-029 Reset mid-operation SHALL discard all in-flight groups; no release is required afterwards.
REQ-030 err_sticky SHALL clear only on reset.

Structure
REQ-031 EVDB_ENTRY_NUM, the group-state enum typedef and GRP index width SHALL live in vector_cache_pkg.
REQ-032 The drain FIFO SHALL be one sub-module, vec_cache_idx_fifo (parameterised depth/width, registered head).

Verification
REQ-033 Reset, 8 back-to-back alloc requests -> grants 0..7, free_cnt 8->0, alloc_req_rdy=0 after 8th.
REQ-034 Fill groups 5,2,7 in that order -> drain_grp_idx presents 5,2,7 with drain_rdy=1; states FILLED->DRAIN.
REQ-035 All full, release group 3 while alloc_req_vld=1 -> no grant that cycle, grant of 3 next cycle, free_cnt 0->1->0.
REQ-036 Release on IDLE group 4 -> err_sticky=1, free_cnt unchanged, group 4 still IDLE.
REQ-037 Same-cycle alloc, fill, drain pop, release on distinct groups -> all four transitions, free_cnt unchanged.
REQ-038 Assert rst_n with 3 groups in DRAIN and FIFO holding 2 -> all outputs at reset values, next alloc returns group 0.
